pip_cla_sub: RTL and testbench
==============================

Name: pip_cla_sub

Overview:
- Pipelined, registered N-bit subtractor computing d = a - b - bin, the subtract counterpart of the team's pipelined carry-lookahead adder.
- Uses the same group carry-lookahead structure: a + ~b + ~bin, with one 4-bit lookahead group resolved per pipeline stage.
- Adds a valid pipeline, a global stall enable and a synchronous reset, so it can sit directly in the datapath.
- Accepts one operation per clock and produces a borrow-out and a signed-overflow flag.

Parameters:
- WIDTH, 20, operand/result width; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; fixed at 4 in this revision.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, pipeline advance; 0 freezes every stage.
- vin, in, 1, operands valid this cycle.
- a, in, WIDTH, minuend.
- b, in, WIDTH, subtrahend.
- bin, in, 1, borrow-in.
- vout, out, 1, result valid.
- d, out, WIDTH, difference, modulo 2^WIDTH.
- bout, out, 1, borrow-out; 1 iff a < b + bin (unsigned).
- ovf, out, 1, signed overflow.

Behaviour:
- Derived constants: NGRP = WIDTH/GROUP (5); LAT = NGRP+3 (8) register stages.
- Stage 0: register a, b, bin and vin.
- Stage 1: compute and register p = a ^ ~b and g = a & ~b. Carry-in c0 = ~bin.
- Stages 2..NGRP+1: stage k+2 resolves group k. It takes the group carry-in from the previous stage and produces the 3 internal carries and the group carry-out.
  - Not-yet-consumed p bits and already-resolved carries are delay-matched forward, one register per stage.
- Stage NGRP+2 (output stage):
  - d = p ^ {c[WIDTH-1:1], c0}
  - bout = ~c_out
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]); the a and b MSBs are delay-matched.
- Latency: operands sampled at edge n with en=1 and vin=1 appear with vout=1 after edge n+7, when en stays 1 throughout.
- Throughput: one operation per cycle; back-to-back operands emerge in order, one per cycle.
- vin=0 cycles travel as bubbles. vout=0 for them, and d/bout/ovf hold their last valid values (they do not update).
- en=0: all data and valid registers hold, and outputs remain static. Latency extends by exactly the number of stalled cycles, with no loss or duplication. Operands presented while en=0 are ignored.
- rst=1 at an edge:
  - all valid bits cleared;
  - vout, d, bout, ovf = 0;
  - data registers may be cleared or left as-is, provided no pre-reset operand ever produces vout=1.
- rst has priority over en.
- Reset mid-operation: everything in flight is discarded. The first operand sampled on the first edge with rst=0 is processed normally.
- Boundaries:
  - 0 - 0 - 1 gives d = all ones, bout=1.
  - a == b with bin=0 gives d=0, bout=0.
  - b = all ones gives a correct borrow for any a.

Decomposition:
- Shared package holds WIDTH, GROUP, the derived NGRP and LAT, and a localparam for the output-stage index.
- One natural sub-module, cla_group4: combinational 4-bit lookahead group.
  - Inputs: p[3:0], g[3:0], cin.
  - Outputs: c[2:0], group P, group G, cout.
  - Instantiated NGRP times, each between that group's pipeline registers.
- Delay-matching registers are written as a generate loop inside pip_cla_sub, not as per-width delay modules.

Test Plan:
- Reset, then a=0x00005, b=0x00003, bin=0 → after edge n+7: vout=1, d=0x00002, bout=0, ovf=0; vout=0 on the following cycle.
- a=0x00000, b=0x00001, bin=0 → d=0xFFFFF, bout=1, ovf=0.
- a=0x80000, b=0x00001, bin=0 → d=0x7FFFF, bout=0, ovf=1. Also a=0x7FFFF, b=0xFFFFF → d=0x80000, bout=1, ovf=1.
- 8 consecutive vin=1 operands, including a=0x12345, b=0x12345, bin=1 (→ d=0xFFFFF, bout=1) and a=0x0F777, b=0x07178, bin=0 (→ d=0x085FF, bout=0) → 8 consecutive vout pulses, in order, all matching a reference model.
- Stream 5 operands, drop en to 0 for 3 cycles mid-stream → outputs frozen during the stall, every result delayed by exactly 3 cycles, none lost or duplicated.
- Fill the pipe, assert rst for 1 cycle → vout=0 and d=0 after that edge, no stale result ever appears. An operand sampled on the first post-reset edge appears 7 edges later.

Source files
------------

// File: rtl/pip_cla_sub_pkg.sv
// Shared constants for the pipelined carry-lookahead subtractor.
//   CLA_WIDTH     : operand/result width
//   CLA_GROUP     : bits per lookahead group (fixed at 4)
//   CLA_NGRP      : number of lookahead groups, one resolved per stage
//   CLA_LAT       : total register stages from operand capture to result
//   CLA_OUT_STAGE : index of the output register stage
package pip_cla_sub_pkg;

  localparam int CLA_WIDTH     = 20;
  localparam int CLA_GROUP     = 4;
  localparam int CLA_NGRP      = CLA_WIDTH / CLA_GROUP;
  localparam int CLA_LAT       = CLA_NGRP + 3;
  localparam int CLA_OUT_STAGE = CLA_NGRP + 2;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
//   p[3:0], g[3:0] : per-bit propagate / generate
//   cin            : group carry-in
//   c[2:0]         : carries into bits 1..3 of the group
//   grp_p, grp_g   : group propagate / generate
//   cout           : group carry-out
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [2:0] c,
  output logic       grp_p,
  output logic       grp_g,
  output logic       cout
);

  always_comb begin
    c[0]  = g[0] | (p[0] & cin);
    c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cout  = grp_g | (grp_p & cin);
  end

endmodule

// File: rtl/pip_cla_sub.sv
// Pipelined carry-lookahead subtractor: d = a - b - bin, computed as
// a + ~b + ~bin with one 4-bit lookahead group resolved per stage.
//   clk, rst : clock, synchronous active-high reset
//   en       : pipeline advance (0 freezes every stage)
//   vin      : operands valid
//   a, b     : minuend, subtrahend
//   bin      : borrow-in
//   vout     : result valid
//   d        : difference modulo 2^WIDTH
//   bout     : borrow-out (a < b + bin, unsigned)
//   ovf      : signed overflow
module pip_cla_sub
  import pip_cla_sub_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             vout,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP;
  // Last carry-resolution stage; the output register follows it.
  localparam int LAST = NGRP + 1;

  // Stage 0: raw operand capture.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             bin_reg;
  logic             v0_reg;

  // Stages 1..LAST. c_reg[s][i] is the carry into bit i; bit 0 holds ~bin
  // and bit WIDTH the final carry-out. Bits of groups not yet resolved are 0.
  logic [WIDTH-1:0] p_reg    [1:LAST];
  logic [WIDTH-1:0] g_reg    [1:NGRP];
  logic [WIDTH:0]   c_reg    [1:LAST];
  logic             amsb_reg [1:LAST];
  logic             bmsb_reg [1:LAST];
  logic             v_reg    [1:LAST];

  // Carry vectors after each group resolves; entry s feeds stage s.
  logic [LAST:2][WIDTH:0] c_next_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_reg  <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      bin_reg <= 1'b0;
    end else if (en) begin
      v0_reg  <= vin;
      a_reg   <= a;
      b_reg   <= b;
      bin_reg <= bin;
    end
  end

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [2:0]     c_int;
      logic           c_out;
      logic [WIDTH:0] c_nxt;

      // Group P/G are not needed here: each group's carry-in is already
      // resolved by the time its stage runs, so cout is used directly.
      cla_group4 u_grp (
        .p     (p_reg[gi+1][GROUP*gi +: GROUP]),
        .g     (g_reg[gi+1][GROUP*gi +: GROUP]),
        .cin   (c_reg[gi+1][GROUP*gi]),
        .c     (c_int),
        .grp_p (),
        .grp_g (),
        .cout  (c_out)
      );

      always_comb begin
        c_nxt                        = c_reg[gi+1];
        c_nxt[GROUP*gi+1 +: 3]       = c_int;
        c_nxt[GROUP*gi+GROUP]        = c_out;
      end

      assign c_next_all[gi+2] = c_nxt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= LAST; s++) begin
        v_reg[s]    <= 1'b0;
        p_reg[s]    <= '0;
        c_reg[s]    <= '0;
        amsb_reg[s] <= 1'b0;
        bmsb_reg[s] <= 1'b0;
      end
      for (int s = 1; s <= NGRP; s++) begin
        g_reg[s] <= '0;
      end
    end else if (en) begin
      // Stage 1: subtract is add with inverted subtrahend and carry-in ~bin.
      v_reg[1]    <= v0_reg;
      p_reg[1]    <= a_reg ^ ~b_reg;
      g_reg[1]    <= a_reg & ~b_reg;
      c_reg[1]    <= {{WIDTH{1'b0}}, ~bin_reg};
      amsb_reg[1] <= a_reg[WIDTH-1];
      bmsb_reg[1] <= b_reg[WIDTH-1];
      // Stages 2..LAST: one group resolved per stage, everything else
      // delay-matched forward.
      for (int s = 2; s <= LAST; s++) begin
        v_reg[s]    <= v_reg[s-1];
        p_reg[s]    <= p_reg[s-1];
        c_reg[s]    <= c_next_all[s];
        amsb_reg[s] <= amsb_reg[s-1];
        bmsb_reg[s] <= bmsb_reg[s-1];
      end
      for (int s = 2; s <= NGRP; s++) begin
        g_reg[s] <= g_reg[s-1];
      end
    end
  end

  // Output stage. Results only update on valid slots so bubbles leave the
  // last result visible.
  logic [WIDTH-1:0] d_next;
  assign d_next = p_reg[LAST] ^ c_reg[LAST][WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vout <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      vout <= v_reg[LAST];
      if (v_reg[LAST]) begin
        d    <= d_next;
        bout <= ~c_reg[LAST][WIDTH];
        ovf  <= (amsb_reg[LAST] != bmsb_reg[LAST]) &&
                (d_next[WIDTH-1] != amsb_reg[LAST]);
      end
    end
  end

endmodule

// File: tb/tb_pip_cla_sub.sv
// Directed testbench for pip_cla_sub: hand-computed vectors, cycle-accurate
// expectation of when each result emerges, stalls and mid-stream reset.
module tb_pip_cla_sub;
  import pip_cla_sub_pkg::*;

  localparam int W = CLA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         vin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         vout;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  pip_cla_sub dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .vin  (vin),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .vout (vout),
    .d    (d),
    .bout (bout),
    .ovf  (ovf)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic [31:0]  due;
    logic [31:0]  idx;
  } exp_t;

  exp_t q[$];

  // Hand-computed vectors: a - b - bin -> d, bout, ovf.
  logic [W-1:0] va  [16];
  logic [W-1:0] vb  [16];
  logic         vbi [16];
  logic [W-1:0] vd  [16];
  logic         vbo [16];
  logic         vov [16];

  int           en_cnt   = 0;
  int           cyc      = 0;
  logic         exp_vout = 1'b0;
  logic [W-1:0] last_d   = '0;
  logic         last_bo  = 1'b0;
  logic         last_ov  = 1'b0;

  // One clock: drive inputs, take the edge, update expectations, check 1ns later.
  task automatic step(input logic r, input logic e, input logic v, input int idx);
    rst = r;
    en  = e;
    vin = v;
    a   = va[idx];
    b   = vb[idx];
    bin = vbi[idx];
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      exp_vout = 1'b0;
      last_d   = '0;
      last_bo  = 1'b0;
      last_ov  = 1'b0;
    end else if (e) begin
      en_cnt++;
      if (v) q.push_back('{vd[idx], vbo[idx], vov[idx], 32'(en_cnt + 7), 32'(idx)});
      exp_vout = (q.size() > 0) && (q[0].due == 32'(en_cnt));
      if (exp_vout) begin
        last_d  = q[0].d;
        last_bo = q[0].bout;
        last_ov = q[0].ovf;
        $display("result cyc=%0d vec=%0d d=%h bout=%0b ovf=%0b", cyc, q[0].idx, d, bout, ovf);
        void'(q.pop_front());
      end
    end
    #1;
    check($sformatf("vout@%0d", cyc), 32'(vout), 32'(exp_vout));
    check($sformatf("d@%0d", cyc), 32'(d), 32'(last_d));
    check($sformatf("bout@%0d", cyc), 32'(bout), 32'(last_bo));
    check($sformatf("ovf@%0d", cyc), 32'(ovf), 32'(last_ov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    va  = '{20'h00005, 20'h00000, 20'h80000, 20'h7FFFF, 20'h00000, 20'h12345, 20'h0F777, 20'hABCDE,
            20'h12345, 20'hFFFFF, 20'h80000, 20'h00010, 20'h7FFFF, 20'h55555, 20'h00001, 20'hFFFFF};
    vb  = '{20'h00003, 20'h00001, 20'h00001, 20'hFFFFF, 20'h00000, 20'h12345, 20'h07178, 20'hABCDE,
            20'hFFFFF, 20'hFFFFF, 20'h7FFFF, 20'h00020, 20'h80000, 20'h2AAAA, 20'h00000, 20'h00000};
    vbi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vd  = '{20'h00002, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'hFFFFF, 20'hFFFFF, 20'h085FF, 20'h00000,
            20'h12346, 20'hFFFFF, 20'h00001, 20'hFFFF0, 20'hFFFFF, 20'h2AAAA, 20'h00000, 20'hFFFFF};
    vbo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset with operands presented; second reset cycle has en=0 (rst wins).
    step(1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1);

    // Single operation: latency and single-cycle vout pulse.
    step(1'b0, 1'b1, 1'b1, 0);
    idle(9);

    // Isolated boundary cases.
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 1'b1, i);
      idle(8);
    end

    // Eight back-to-back operations.
    for (int i = 4; i <= 11; i++) step(1'b0, 1'b1, 1'b1, i);
    idle(9);

    // Five operations with a 3-cycle stall mid-stream (operands during the
    // stall must be ignored), then a 2-cycle stall while results emerge.
    step(1'b0, 1'b1, 1'b1, 12);
    step(1'b0, 1'b1, 1'b1, 13);
    step(1'b0, 1'b1, 1'b1, 14);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 1'b1, 15);
    step(1'b0, 1'b1, 1'b1, 0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    idle(8);

    // Fill the pipe, reset for one cycle, then an operand on the first
    // post-reset edge must be the only result to appear.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b1, i);
    step(1'b1, 1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 1'b1, 8);
    idle(9);

    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
